// File: rtl/tpumac_vec.sv
// Vector MAC: LANES parallel signed multiply-accumulate lanes sharing one A operand, with a
// start/beat/result handshake. Define TPUMAC_SAT_EN for saturating adds with sticky ovf flags.
module tpumac_vec #(
    parameter int unsigned BITS_AB = 8,
    parameter int unsigned BITS_C  = 16,
    parameter int unsigned LANES   = 4,
    parameter int unsigned KMAX    = 256,
    localparam int unsigned CNT_W  = $clog2(KMAX + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CNT_W-1:0]          len,
    input  logic                      clr,
    input  logic                      WrEn,
    input  logic [LANES*BITS_C-1:0]   Cin,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BITS_AB-1:0]        Ain,
    input  logic [LANES*BITS_AB-1:0]  Bin,
    output logic [BITS_AB-1:0]        Aout,
    output logic [LANES*BITS_AB-1:0]  Bout,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*BITS_C-1:0]   Cout,
    output logic                      busy,
    output logic [LANES-1:0]          ovf
);

    localparam int unsigned PROD_W = 2 * BITS_AB;
`ifdef TPUMAC_SAT_EN
    localparam int unsigned SUM_W = BITS_C + 1;
    localparam logic [BITS_C-1:0] ACC_MAX = {1'b0, {(BITS_C-1){1'b1}}};
    localparam logic [BITS_C-1:0] ACC_MIN = {1'b1, {(BITS_C-1){1'b0}}};
`else
    localparam int unsigned SUM_W = BITS_C;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                rem_q, rem_d;
    logic [LANES-1:0][BITS_C-1:0]    acc_q, acc_d;
    logic [BITS_AB-1:0]              a_q, a_d;
    logic [LANES*BITS_AB-1:0]        b_q, b_d;
    logic                            in_ready_q, in_ready_d;
    logic                            out_valid_q, out_valid_d;
    logic                            busy_q, busy_d;
    logic                            beat;

    logic signed [PROD_W-1:0]        lane_prod [LANES];
    logic signed [SUM_W-1:0]         lane_sum  [LANES];
    logic [LANES-1:0][BITS_C-1:0]    lane_res;
`ifdef TPUMAC_SAT_EN
    logic [LANES-1:0]                lane_clip;
    logic [LANES-1:0]                ovf_q, ovf_d;
`endif

    assign beat = in_valid && in_ready_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (len == '0) ? S_DONE : S_ACCUM;
            S_ACCUM: if (beat && rem_q == CNT_W'(1)) state_d = S_DONE;
            S_DONE:  if (out_valid_q && out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b1;
        case (state_d)
            S_ACCUM: in_ready_d  = 1'b1;
            S_DONE:  out_valid_d = 1'b1;
            default: busy_d      = 1'b0;
        endcase
    end

    // Per-lane product and add, clamped or wrapped depending on build
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_prod[i] = PROD_W'($signed(Ain)) * PROD_W'($signed(Bin[i*BITS_AB +: BITS_AB]));
            lane_sum[i]  = SUM_W'($signed(acc_q[i])) + SUM_W'(lane_prod[i]);
`ifdef TPUMAC_SAT_EN
            lane_clip[i] = lane_sum[i][SUM_W-1] != lane_sum[i][SUM_W-2];
            if (lane_clip[i]) lane_res[i] = lane_sum[i][SUM_W-1] ? ACC_MIN : ACC_MAX;
            else              lane_res[i] = lane_sum[i][BITS_C-1:0];
`else
            lane_res[i]  = lane_sum[i];
`endif
        end
    end

    // Datapath next values: preload/clear in IDLE, accumulate on accepted beats
    always_comb begin
        rem_d = rem_q;
        acc_d = acc_q;
        a_d   = a_q;
        b_d   = b_q;
`ifdef TPUMAC_SAT_EN
        ovf_d = ovf_q;
`endif
        if (state_q == S_IDLE) begin
            if (WrEn)               acc_d = Cin;
            else if (start && clr)  acc_d = '0;
            if (start)              rem_d = len;
`ifdef TPUMAC_SAT_EN
            if (start || WrEn)      ovf_d = '0;
`endif
        end else if (state_q == S_ACCUM && beat) begin
            rem_d = rem_q - CNT_W'(1);
            a_d   = Ain;
            b_d   = Bin;
            acc_d = lane_res;
`ifdef TPUMAC_SAT_EN
            ovf_d = ovf_q | lane_clip;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q       <= '0;
            acc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef TPUMAC_SAT_EN
            ovf_q       <= '0;
`endif
        end else begin
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef TPUMAC_SAT_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign Cout      = acc_q;
    assign Aout      = a_q;
    assign Bout      = b_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
`ifdef TPUMAC_SAT_EN
    assign ovf       = ovf_q;
`else
    assign ovf       = '0;
`endif

endmodule

// File: tb/tb_tpumac_vec.sv
// Scoreboard bench for tpumac_vec: directed scenarios plus random jobs, checked against an
// integer-arithmetic reference model. Honours TPUMAC_SAT_EN the same way the design does.
module tb_tpumac_vec;

    localparam int BA   = 8;
    localparam int BC   = 16;
    localparam int L    = 4;
    localparam int CW   = 9;
    localparam int MAXV = 32767;
    localparam int MINV = -32768;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, clr, WrEn, in_valid, out_ready;
    logic [CW-1:0]     len;
    logic [L*BC-1:0]   Cin, Cout;
    logic              in_ready, out_valid, busy;
    logic [BA-1:0]     Ain, Aout;
    logic [L*BA-1:0]   Bin, Bout;
    logic [L-1:0]      ovf;

    tpumac_vec #(.BITS_AB(BA), .BITS_C(BC), .LANES(L), .KMAX(256)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .clr(clr), .WrEn(WrEn), .Cin(Cin),
        .in_valid(in_valid), .in_ready(in_ready), .Ain(Ain), .Bin(Bin), .Aout(Aout),
        .Bout(Bout), .out_valid(out_valid), .out_ready(out_ready), .Cout(Cout),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [L*BC-1:0] cout;
        logic [L-1:0]    ov;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;
    int           m_acc[L];
    logic [L-1:0] m_ovf;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int wrap_c(input int s);
        logic signed [BC-1:0] t;
        t = BC'(s);
        return int'(t);
    endfunction

    function automatic logic [L*BC-1:0] pack_model();
        logic [L*BC-1:0] v;
        for (int i = 0; i < L; i++) v[i*BC +: BC] = BC'(m_acc[i]);
        return v;
    endfunction

    task automatic model_load(input logic [L*BC-1:0] c);
        logic signed [BC-1:0] t;
        for (int i = 0; i < L; i++) begin
            t = c[i*BC +: BC];
            m_acc[i] = int'(t);
        end
    endtask

    task automatic model_beat(input logic [BA-1:0] a, input logic [L*BA-1:0] b);
        logic signed [BA-1:0] sa, sb;
        int s;
        sa = a;
        for (int i = 0; i < L; i++) begin
            sb = b[i*BA +: BA];
            s  = m_acc[i] + int'(sa) * int'(sb);
`ifdef TPUMAC_SAT_EN
            if (s > MAXV) begin s = MAXV; m_ovf[i] = 1'b1; end
            if (s < MINV) begin s = MINV; m_ovf[i] = 1'b1; end
            m_acc[i] = s;
`else
            m_acc[i] = wrap_c(s);
`endif
        end
    endtask

    // Monitor: compare whenever a result is handed over
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_result", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_cout", Cout, e.cout);
                chk("sb_ovf", 64'(ovf), 64'(e.ov));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_garbage(input bit on);
        start = on ? 1'($urandom) : 1'b0;
        clr   = on ? 1'($urandom) : 1'b0;
        WrEn  = on ? 1'($urandom) : 1'b0;
        len   = CW'($urandom_range(0, 5));
        Cin   = {$urandom, $urandom};
    endtask

    task automatic wren_only(input logic [L*BC-1:0] c);
        WrEn = 1'b1;
        Cin  = c;
        model_load(c);
        m_ovf = '0;
        tick();
        WrEn = 1'b0;
    endtask

    task automatic issue_start(input int n, input bit c_clr, input bit wr, input logic [L*BC-1:0] c);
        start = 1'b1;
        len   = CW'(n);
        clr   = c_clr;
        WrEn  = wr;
        Cin   = c;
        if (wr)         model_load(c);
        else if (c_clr) for (int i = 0; i < L; i++) m_acc[i] = 0;
        m_ovf = '0;
        tick();
        start = 1'b0;
        clr   = 1'b0;
        WrEn  = 1'b0;
    endtask

    task automatic issue_beat(input logic [BA-1:0] a, input logic [L*BA-1:0] b,
                              input int gap, input bit garbage);
        bit taken;
        repeat (gap) begin
            in_valid = 1'b0;
            set_garbage(garbage);
            tick();
        end
        set_garbage(1'b0);
        Ain      = a;
        Bin      = b;
        in_valid = 1'b1;
        taken    = 1'b0;
        for (int t = 0; t < 20 && !taken; t++) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!taken) begin
            chk("beat_accept_timeout", 64'd0, 64'd1);
        end else begin
            model_beat(a, b);
            chk("aout", 64'(Aout), 64'(a));
            chk("bout", 64'(Bout), 64'(b));
        end
    endtask

    // Called right after the edge that completes the job (last beat or zero-length start)
    task automatic finish_job(input int bp, input bit garbage);
        exp_t e;
        e.cout = pack_model();
        e.ov   = m_ovf;
        sb_q.push_back(e);
        @(negedge clk);
        chk("out_valid_latency", 64'(out_valid), 64'd1);
        chk("in_ready_in_done", 64'(in_ready), 64'd0);
        repeat (bp) begin
            @(posedge clk);
            #1;
            set_garbage(garbage);
            @(negedge clk);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_cout", Cout, e.cout);
        end
        @(posedge clk);
        #1;
        set_garbage(1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_handshake", {62'd0, busy, out_valid}, 64'd0);
        chk("retained_cout", Cout, e.cout);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [L*BC-1:0] ov_exp;
        rst = 1'b1; start = 1'b0; clr = 1'b0; WrEn = 1'b0; len = '0; Cin = '0;
        in_valid = 1'b0; Ain = '0; Bin = '0; out_ready = 1'b0;
        for (int i = 0; i < L; i++) m_acc[i] = 0;
        m_ovf = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cout", Cout, 64'd0);
        chk("reset_ctrl", {60'd0, busy, out_valid, in_ready, 1'b0}, 64'd0);
        chk("reset_ab_ovf", {Aout, Bout, ovf}, 44'd0);
        rst = 1'b0;
        tick();

        // Preload then accumulate three beats
        wren_only({16'd40, 16'd30, 16'd20, 16'd10});
        issue_start(3, 1'b0, 1'b0, '0);
        repeat (3) issue_beat(8'd2, {8'd4, 8'd3, 8'd2, 8'd1}, 0, 1'b0);
        finish_job(0, 1'b0);
        chk("preload_accum_const", Cout, {16'd64, 16'd48, 16'd32, 16'd16});

        // Backpressure on both sides with ignored control pulses
        issue_start(2, 1'b1, 1'b0, '0);
        issue_beat(8'hfd, {8'd7, 8'hf9, 8'd100, 8'd5}, 0, 1'b1);
        issue_beat(8'd9, {8'd1, 8'd2, 8'h80, 8'd3}, 3, 1'b1);
        finish_job(5, 1'b1);

        // Overflow scenario on lanes 0 and 1
        issue_start(3, 1'b1, 1'b0, '0);
        repeat (3) issue_beat(8'd127, {8'd0, 8'd0, 8'h80, 8'd127}, 0, 1'b0);
        finish_job(0, 1'b0);
`ifdef TPUMAC_SAT_EN
        ov_exp = {16'd0, 16'd0, 16'h8000, 16'h7fff};
        chk("ovf_const", 64'(ovf), 64'h3);
`else
        ov_exp = {16'd0, 16'd0, 16'd16768, 16'hbd03};
        chk("ovf_const", 64'(ovf), 64'h0);
`endif
        chk("overflow_cout_const", Cout, ov_exp);

        // Zero-length job
        wren_only({16'd8, 16'd7, 16'd6, 16'd5});
        issue_start(0, 1'b0, 1'b0, '0);
        finish_job(0, 1'b0);
        chk("zero_len_cout_const", Cout, {16'd8, 16'd7, 16'd6, 16'd5});

        // Reset in the middle of a job
        issue_start(4, 1'b1, 1'b0, '0);
        issue_beat(8'd11, {8'd3, 8'd4, 8'd5, 8'd6}, 0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midreset_cout", Cout, 64'd0);
        chk("midreset_ctrl", {60'd0, busy, out_valid, in_ready, 1'b0}, 64'd0);
        chk("midreset_ab_ovf", {Aout, Bout, ovf}, 44'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < L; i++) m_acc[i] = 0;
        m_ovf = '0;
        issue_start(1, 1'b1, 1'b0, '0);
        issue_beat(8'd3, {8'd1, 8'd1, 8'd1, 8'd1}, 0, 1'b0);
        finish_job(0, 1'b0);
        chk("after_reset_const", Cout, {16'd3, 16'd3, 16'd3, 16'd3});

        // Random jobs
        for (int j = 0; j < 30; j++) begin
            int n;
            n = $urandom_range(0, 6);
            if ($urandom_range(0, 3) == 0) wren_only({$urandom, $urandom});
            issue_start(n, 1'($urandom), 1'($urandom_range(0, 3) == 0), {$urandom, $urandom});
            for (int b = 0; b < n; b++)
                issue_beat(8'($urandom), $urandom, $urandom_range(0, 2), 1'($urandom));
            finish_job($urandom_range(0, 3), 1'($urandom));
        end

        repeat (3) tick();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
